sr_reg_bank: RTL and testbench

- Parametrised bank of WIDTH independent clocked SR storage cells.
- Adds a selectable resolution for the S=R=1 conflict, a global enable, and a synchronous clear.
- Generates per-channel rise/fall pulses and a sticky conflict monitor with a saturating counter.
- Used as the general-purpose status/flag register for control blocks that need set/reset semantics across many bits.

---
 rtl/sr_reg_bank.sv | 90 +++++++++
 tb/tb_sr_reg_bank.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sr_reg_bank.sv
// rtl/sr_reg_bank.sv - bank of clocked SR cells with conflict resolution, edge pulses and conflict monitor
module sr_reg_bank #(
  parameter int               WIDTH = 8,
  parameter int               MODE  = 0,
  parameter logic [WIDTH-1:0] INIT  = {WIDTH{1'b0}},
  parameter int               CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             conflict_ack,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  // Out-of-range parameters stop elaboration rather than producing a silently odd bank.
  if (WIDTH < 1 || WIDTH > 64 || MODE < 0 || MODE > 3 || CNT_W < 2 || CNT_W > 16) begin : g_bad_param
    $error("sr_reg_bank: illegal parameter value");
  end

  logic [WIDTH-1:0] q_next;
  logic             hit;

  // Next channel state: clear beats enable; S=R=1 resolved by MODE.
  always_comb begin
    q_next = q;
    if (clr) begin
      q_next = INIT;
    end else if (en) begin
      for (int i = 0; i < WIDTH; i++) begin
        case ({s[i], r[i]})
          2'b01:   q_next[i] = 1'b0;
          2'b10:   q_next[i] = 1'b1;
          2'b11: begin
            case (MODE)
              1:       q_next[i] = 1'b1;
              2:       q_next[i] = 1'b0;
              3:       q_next[i] = ~q[i];
              default: q_next[i] = q[i];
            endcase
          end
          default: q_next[i] = q[i];
        endcase
      end
    end
  end

  // A conflict cycle is counted once no matter how many channels collide.
  assign hit  = en & ~clr & (|(s & r));
  assign qbar = ~q;

  // Channel state and registered edge pulses, aligned with the new q value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q    <= INIT;
      rise <= '0;
      fall <= '0;
    end else begin
      q    <= q_next;
      rise <= ~q & q_next;
      fall <= q & ~q_next;
    end
  end

  // Sticky conflict flag and saturating counter; a new hit outranks the ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else if (hit) begin
      conflict <= 1'b1;
      if (conflict_ack) begin
        conflict_cnt <= CNT_W'(1);
      end else if (conflict_cnt != {CNT_W{1'b1}}) begin
        conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end else if (conflict_ack) begin
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_sr_reg_bank.sv
// tb/tb_sr_reg_bank.sv - directed self-checking bench for sr_reg_bank
module tb_sr_reg_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       clr;
  logic [7:0] s;
  logic [7:0] r;
  logic       ack;

  logic [7:0] q0, qb0, ri0, fa0;
  logic [7:0] q1, qb1, ri1, fa1;
  logic [7:0] q2, qb2, ri2, fa2;
  logic [7:0] q3, qb3, ri3, fa3;
  logic       c0, c1, c2, c3;
  logic [7:0] n0, n2, n3;
  logic [1:0] n1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sr_reg_bank #(.WIDTH(8), .MODE(0), .INIT(8'hA5), .CNT_W(8)) u0 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .s(s), .r(r), .conflict_ack(ack),
    .q(q0), .qbar(qb0), .rise(ri0), .fall(fa0), .conflict(c0), .conflict_cnt(n0));
  sr_reg_bank #(.WIDTH(8), .MODE(1), .INIT(8'h00), .CNT_W(2)) u1 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .s(s), .r(r), .conflict_ack(ack),
    .q(q1), .qbar(qb1), .rise(ri1), .fall(fa1), .conflict(c1), .conflict_cnt(n1));
  sr_reg_bank #(.WIDTH(8), .MODE(2), .INIT(8'h00), .CNT_W(8)) u2 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .s(s), .r(r), .conflict_ack(ack),
    .q(q2), .qbar(qb2), .rise(ri2), .fall(fa2), .conflict(c2), .conflict_cnt(n2));
  sr_reg_bank #(.WIDTH(8), .MODE(3), .INIT(8'h00), .CNT_W(8)) u3 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .s(s), .r(r), .conflict_ack(ack),
    .q(q3), .qbar(qb3), .rise(ri3), .fall(fa3), .conflict(c3), .conflict_cnt(n3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic c, input logic [7:0] sv,
                       input logic [7:0] rv, input logic a);
    en = e; clr = c; s = sv; r = rv; ack = a;
  endtask

  initial begin
    // Test 1: reset values and basic set/reset
    reset = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc(); cyc();
    chk("rst_q0", q0, 8'hA5);
    chk("rst_qbar0", qb0, 8'h5A);
    chk("rst_rise0", ri0, 8'h00);
    chk("rst_fall0", fa0, 8'h00);
    chk("rst_conf0", c0, 1'b0);
    chk("rst_cnt0", n0, 8'd0);
    chk("rst_q1", q1, 8'h00);

    reset = 1'b1;
    drive(1'b1, 1'b0, 8'h0F, 8'hF0, 1'b0);
    cyc();
    chk("set_q0", q0, 8'h0F);
    chk("set_rise0", ri0, 8'h0A);
    chk("set_fall0", fa0, 8'hA0);
    chk("set_q3", q3, 8'h0F);
    chk("set_rise3", ri3, 8'h0F);
    chk("set_conf0", c0, 1'b0);

    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc();
    chk("idle_rise0", ri0, 8'h00);
    chk("idle_fall0", fa0, 8'h00);
    chk("idle_q0", q0, 8'h0F);

    // Test 2: S=R=1 resolution in every mode
    drive(1'b1, 1'b0, 8'h81, 8'h81, 1'b0);
    cyc();
    chk("m0_q", q0, 8'h0F);
    chk("m1_q", q1, 8'h8F);
    chk("m2_q", q2, 8'h0E);
    chk("m3_q", q3, 8'h8E);
    chk("m0_conf", c0, 1'b1);
    chk("m1_conf", c1, 1'b1);
    chk("m2_conf", c2, 1'b1);
    chk("m3_conf", c3, 1'b1);
    chk("m0_cnt", n0, 8'd1);
    chk("m1_cnt", n1, 2'd1);
    chk("m2_cnt", n2, 8'd1);
    chk("m3_cnt", n3, 8'd1);
    chk("m1_rise", ri1, 8'h80);
    chk("m2_fall", fa2, 8'h01);
    chk("m3_qbar", qb3, 8'h71);

    // Test 3: enable gating and clear priority
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    cyc();
    chk("ack_conf0", c0, 1'b0);
    chk("ack_cnt0", n0, 8'd0);

    drive(1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0);
    cyc();
    chk("en0_q0", q0, 8'h0F);
    chk("en0_q3", q3, 8'h8E);
    chk("en0_conf0", c0, 1'b0);
    chk("en0_rise3", ri3, 8'h00);

    drive(1'b1, 1'b0, 8'h3C, 8'hC3, 1'b0);
    cyc();
    chk("pre_clr_q1", q1, 8'h3C);
    chk("pre_clr_q0", q0, 8'h3C);

    drive(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b0);
    cyc();
    chk("clr_q1", q1, 8'h00);
    chk("clr_fall1", fa1, 8'h3C);
    chk("clr_cnt1", n1, 2'd0);
    chk("clr_conf1", c1, 1'b0);
    chk("clr_q0", q0, 8'hA5);
    chk("clr_rise0", ri0, 8'h81);
    chk("clr_fall0", fa0, 8'h18);

    // Test 4: saturating counter on the CNT_W=2 instance
    drive(1'b1, 1'b0, 8'h01, 8'h01, 1'b0);
    cyc(); chk("sat1", n1, 2'd1);
    cyc(); chk("sat2", n1, 2'd2);
    cyc(); chk("sat3", n1, 2'd3);
    cyc(); chk("sat4", n1, 2'd3);
    cyc(); chk("sat5", n1, 2'd3);
    chk("sat_cnt0", n0, 8'd5);
    chk("sat_q3", q3, 8'h01);

    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    cyc();
    chk("ack_nohit_conf", c1, 1'b0);
    chk("ack_nohit_cnt", n1, 2'd0);

    drive(1'b1, 1'b0, 8'h01, 8'h01, 1'b1);
    cyc();
    chk("ack_hit_conf", c1, 1'b1);
    chk("ack_hit_cnt", n1, 2'd1);
    chk("ack_hit_cnt0", n0, 8'd1);

    // Test 5: MODE3 toggling from q[0]=0
    chk("tog_start", q3[0], 1'b0);
    drive(1'b1, 1'b0, 8'h01, 8'h01, 1'b0);
    cyc(); chk("tog1_q", q3[0], 1'b1); chk("tog1_rise", ri3[0], 1'b1); chk("tog1_fall", fa3[0], 1'b0);
    cyc(); chk("tog2_q", q3[0], 1'b0); chk("tog2_rise", ri3[0], 1'b0); chk("tog2_fall", fa3[0], 1'b1);
    cyc(); chk("tog3_q", q3[0], 1'b1); chk("tog3_rise", ri3[0], 1'b1); chk("tog3_fall", fa3[0], 1'b0);
    cyc(); chk("tog4_q", q3[0], 1'b0); chk("tog4_rise", ri3[0], 1'b0); chk("tog4_fall", fa3[0], 1'b1);
    chk("tog_cnt1", n1, 2'd3);

    // Test 6: asynchronous reset between edges
    drive(1'b1, 1'b0, 8'h03, 8'h01, 1'b0);
    cyc();
    chk("pre_rst_rise1", ri1, 8'h02);
    chk("pre_rst_cnt1", n1, 2'd3);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_q1", q1, 8'h00);
    chk("arst_qbar1", qb1, 8'hFF);
    chk("arst_rise1", ri1, 8'h00);
    chk("arst_cnt1", n1, 2'd0);
    chk("arst_conf1", c1, 1'b0);
    chk("arst_q0", q0, 8'hA5);
    chk("arst_cnt0", n0, 8'd0);

    drive(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0);
    cyc();
    chk("hold_rst_q0", q0, 8'hA5);
    chk("hold_rst_rise0", ri0, 8'h00);
    chk("hold_rst_q1", q1, 8'h00);

    reset = 1'b1;
    cyc();
    chk("post_rst_q0", q0, 8'hFF);
    chk("post_rst_rise0", ri0, 8'h5A);
    chk("post_rst_q2", q2, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
